pc_fetch_unit: RTL and testbench

- Program-counter register plus instruction-fetch sequencer for the 16-bit CPU.
- Sits directly upstream of the PC-select 2:1 mux:
  - Exports PCPlus2 as the sequential candidate.
  - Accepts the mux-selected branch target back via BranchTaken/BranchTarget.
- Issues single-outstanding reads to instruction memory.
- Holds each fetched word for decode under a valid/ready handshake.

---
 rtl/pc_fetch_unit_if.sv | 45 ++++
 rtl/pc_fetch_unit.sv | 129 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if
//   Groups every non-clock/reset signal of the PC / instruction-fetch unit.
//   The fetch unit connects through the master modport. Hazard logic, the
//   PC-select mux, instruction memory and decode connect through the slave
//   modport.
//
//   stall          hazard-logic freeze request
//   branch_taken   one-cycle pulse: load branch_target into the PC
//   branch_target  target from the PC-select mux (bit 0 ignored)
//   pc             current PC register
//   pc_plus2       pc + 2 (sequential candidate for the PC-select mux)
//   mem_req        one-cycle read strobe to instruction memory
//   mem_addr       read address (equals pc)
//   mem_data       read data
//   mem_valid      read data valid, one pulse per request
//   instr          held instruction word
//   instr_valid    instr is valid for decode
//   instr_ready    decode accepts instr
interface pc_fetch_unit_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
);
  logic               stall;
  logic               branch_taken;
  logic [ADDR_W-1:0]  branch_target;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  pc_plus2;
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] mem_data;
  logic               mem_valid;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_ready;

  modport master (
    input  stall, branch_taken, branch_target, mem_data, mem_valid, instr_ready,
    output pc, pc_plus2, mem_req, mem_addr, instr, instr_valid
  );

  modport slave (
    output stall, branch_taken, branch_target, mem_data, mem_valid, instr_ready,
    input  pc, pc_plus2, mem_req, mem_addr, instr, instr_valid
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Program-counter register and single-outstanding instruction-fetch
//   sequencer for the 16-bit CPU. Issues one read per fetch, holds the
//   returned word for decode under a valid/ready handshake, and accepts
//   branch redirects from the PC-select mux at any time.
//
//   clk_i   system clock, rising edge
//   rst_ni  asynchronous active-low reset
//   bus     pc_fetch_unit_if.master (see interface file for signal list)
//
//   RESET_PC must be even.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_REQ  | ready to issue a read for pc (mem_req unless stall/branch)
//   S_WAIT | read outstanding, waiting for mem_valid
//   S_HOLD | instr/instr_valid presented to decode until accepted
module pc_fetch_unit #(
  parameter int              ADDR_W   = 16,
  parameter int              INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  pc_fetch_unit_if.master   bus
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               instr_valid_q, instr_valid_d;
  logic               squash_q, squash_d;

  logic [ADDR_W-1:0]  pc_plus2;
  logic [ADDR_W-1:0]  branch_pc;
  logic               issue;

  assign pc_plus2  = pc_q + ADDR_W'(2);
  assign branch_pc = {bus.branch_target[ADDR_W-1:1], 1'b0};
  assign issue     = (state_q == S_REQ) && !bus.stall && !bus.branch_taken;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    squash_d      = squash_q;

    unique case (state_q)
      S_REQ: begin
        if (bus.branch_taken) begin
          pc_d = branch_pc;
        end else if (issue) begin
          state_d = S_WAIT;
        end
      end

      // Memory cannot be stalled, so returning data is consumed regardless
      // of stall. A redirect racing the return drops the word directly
      // instead of arming squash.
      S_WAIT: begin
        if (bus.mem_valid) begin
          if (bus.branch_taken) begin
            pc_d     = branch_pc;
            squash_d = 1'b0;
            state_d  = S_REQ;
          end else if (squash_q) begin
            squash_d = 1'b0;
            state_d  = S_REQ;
          end else begin
            instr_d       = bus.mem_data;
            instr_valid_d = 1'b1;
            pc_d          = pc_plus2;
            state_d       = S_HOLD;
          end
        end else if (bus.branch_taken) begin
          pc_d     = branch_pc;
          squash_d = 1'b1;
        end
      end

      S_HOLD: begin
        if (bus.branch_taken) begin
          pc_d          = branch_pc;
          instr_valid_d = 1'b0;
          state_d       = S_REQ;
        end else if (bus.instr_ready && !bus.stall) begin
          instr_valid_d = 1'b0;
          state_d       = S_REQ;
        end
      end

      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      squash_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      squash_q      <= squash_d;
    end
  end

  // The strobe is gated by reset so no read escapes while rst_ni is low.
  assign bus.mem_req     = issue && rst_ni;
  assign bus.mem_addr    = pc_q;
  assign bus.pc          = pc_q;
  assign bus.pc_plus2    = pc_plus2;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_valid_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  pc_fetch_unit_if #(.ADDR_W(16), .INSTR_W(16)) bus ();

  pc_fetch_unit #(.ADDR_W(16), .INSTR_W(16), .RESET_PC(16'h0000)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Returns just after a rising edge; inputs are driven here and outputs
  // are sampled a further #1 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete fetch starting in REQ with mem_req expected this cycle.
  task automatic fetch(input logic [15:0] addr, input logic [15:0] data,
                       input int lat, input int hold);
    logic [15:0] next_pc;
    next_pc = addr + 16'd2;
    #1;
    chk("fetch_req", bus.mem_req, 1);
    chk("fetch_addr", bus.mem_addr, addr);
    tick();
    for (int i = 1; i < lat; i++) begin
      #1;
      chk("wait_noreq", bus.mem_req, 0);
      tick();
    end
    bus.mem_valid = 1'b1;
    bus.mem_data  = data;
    #1;
    chk("wait_noreq", bus.mem_req, 0);
    tick();
    bus.mem_valid   = 1'b0;
    bus.mem_data    = 16'h0000;
    bus.instr_ready = (hold == 0);
    #1;
    chk("hold_instr", bus.instr, data);
    chk("hold_valid", bus.instr_valid, 1);
    chk("hold_pc", bus.pc, next_pc);
    chk("hold_pcplus2", bus.pc_plus2, next_pc + 16'd2);
    for (int i = 0; i < hold; i++) begin
      tick();
      #1;
      chk("stable_instr", bus.instr, data);
      chk("stable_valid", bus.instr_valid, 1);
      chk("stable_noreq", bus.mem_req, 0);
    end
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    chk("accept_valid", bus.instr_valid, 0);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 16'h0000;
    bus.mem_data      = 16'h0000;
    bus.mem_valid     = 1'b0;
    bus.instr_ready   = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_pc", bus.pc, 16'h0000);
    chk("rst_valid", bus.instr_valid, 0);
    chk("rst_instr", bus.instr, 16'h0000);
    chk("rst_noreq", bus.mem_req, 0);
    rst_n = 1'b1;

    // Latency-1 fetch then two more, second held 4 cycles: PC 0->2->4->6
    fetch(16'h0000, 16'hA001, 1, 0);
    fetch(16'h0002, 16'hB002, 2, 4);
    fetch(16'h0004, 16'hC003, 1, 0);
    chk("seq_pc", bus.pc, 16'h0006);

    // Branch while WAIT: in-flight 16'hDEAD must be squashed
    #1;
    chk("br_wait_req", bus.mem_req, 1);
    tick();
    bus.branch_taken  = 1'b1;
    bus.branch_target = 16'h0101;
    #1;
    chk("br_wait_noreq", bus.mem_req, 0);
    tick();
    bus.branch_taken = 1'b0;
    chk("br_wait_pc", bus.pc, 16'h0100);
    bus.mem_valid = 1'b1;
    bus.mem_data  = 16'hDEAD;
    tick();
    bus.mem_valid = 1'b0;
    chk("squash_valid", bus.instr_valid, 0);
    chk("squash_instr", bus.instr, 16'hC003);
    fetch(16'h0100, 16'h1111, 1, 0);

    // Branch in the same cycle as mem_valid
    #1;
    chk("br_mv_req", bus.mem_req, 1);
    tick();
    bus.mem_valid     = 1'b1;
    bus.mem_data      = 16'h5555;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 16'h0200;
    tick();
    bus.mem_valid    = 1'b0;
    bus.branch_taken = 1'b0;
    chk("br_mv_pc", bus.pc, 16'h0200);
    chk("br_mv_valid", bus.instr_valid, 0);
    fetch(16'h0200, 16'h2222, 1, 0);

    // Branch in REQ to 16'hFFFF (bit 0 dropped), then wrap-around
    bus.branch_taken  = 1'b1;
    bus.branch_target = 16'hFFFF;
    #1;
    chk("br_req_noreq", bus.mem_req, 0);
    tick();
    bus.branch_taken = 1'b0;
    chk("br_req_pc", bus.pc, 16'hFFFE);
    chk("wrap_pcplus2_pre", bus.pc_plus2, 16'h0000);
    fetch(16'hFFFE, 16'h3333, 1, 0);
    chk("wrap_pc", bus.pc, 16'h0000);
    chk("wrap_pcplus2", bus.pc_plus2, 16'h0002);

    // Branch in HOLD drops the instruction even with instr_ready high
    #1;
    chk("br_hold_req", bus.mem_req, 1);
    tick();
    bus.mem_valid = 1'b1;
    bus.mem_data  = 16'h4444;
    tick();
    bus.mem_valid     = 1'b0;
    bus.instr_ready   = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 16'h0300;
    chk("br_hold_pre", bus.instr_valid, 1);
    tick();
    bus.instr_ready  = 1'b0;
    bus.branch_taken = 1'b0;
    chk("br_hold_valid", bus.instr_valid, 0);
    chk("br_hold_pc", bus.pc, 16'h0300);

    // Stall 3 cycles in REQ, then reset mid-WAIT with a late mem_valid
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_noreq", bus.mem_req, 0);
      chk("stall_pc", bus.pc, 16'h0300);
      tick();
    end
    bus.stall = 1'b0;
    #1;
    chk("unstall_req", bus.mem_req, 1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_pc", bus.pc, 16'h0000);
    chk("midrst_valid", bus.instr_valid, 0);
    chk("midrst_noreq", bus.mem_req, 0);
    tick();
    rst_n         = 1'b1;
    bus.stall     = 1'b1;
    bus.mem_valid = 1'b1;
    bus.mem_data  = 16'hEEEE;
    tick();
    bus.mem_valid = 1'b0;
    bus.stall     = 1'b0;
    chk("late_valid", bus.instr_valid, 0);
    chk("late_instr", bus.instr, 16'h0000);
    chk("late_pc", bus.pc, 16'h0000);
    fetch(16'h0000, 16'h7777, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
